fetch_ctrl: RTL

Fetch-stage controller that owns the program counter and sequences instruction-memory fetches for the pipeline. Each cycle it arbitrates between four next-PC sources: sequential PC+4, the decode-stage branch/jump target, the exception vector and the ERET return address. It drives a single-outstanding request/grant/valid handshake to instruction memory and presents a registered instruction, PC and PC+4 to the IF/ID boundary. It honours hazard stalls and kills wrong-path fetches.

---
 rtl/fetch_ctrl_pkg.sv | 21 ++
 rtl/fetch_ctrl_arb.sv | 42 ++++
 rtl/fetch_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared encodings and defaults for the fetch-stage controller.
package fetch_ctrl_pkg;

  localparam logic [1:0] NPC_NORMAL = 2'b00;
  localparam logic [1:0] NPC_BEQ    = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEFAULT_EXC_VEC  = 32'h0000_4180;

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    WAIT  = 2'b01,
    HOLD  = 2'b10
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_ctrl_arb.sv
// Priority select of the next-PC redirect source: exception, ERET, then branch/jump.
module pc_redirect_arb
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VEC = DEFAULT_EXC_VEC
) (
  input  logic        stall_i,
  input  logic [1:0]  npc_sel_i,
  input  logic [31:0] npc_target_i,
  input  logic        exc_req_i,
  input  logic        eret_req_i,
  input  logic [31:0] epc_i,
  output logic        redirect_valid_o,
  output logic        redirect_flush_o,
  output logic [31:0] redirect_pc_o
);

  logic npc_taken;

  // The reserved select code falls through to sequential fetch.
  assign npc_taken = (npc_sel_i == NPC_BEQ) || (npc_sel_i == NPC_JUMP);

  // NOTE: every output gets a default before the priority chain, so no path can infer a latch.
  always_comb begin
    redirect_valid_o = 1'b0;
    redirect_flush_o = 1'b0;
    redirect_pc_o    = 32'h0;
    if (exc_req_i) begin
      redirect_valid_o = 1'b1;
      redirect_flush_o = 1'b1;
      redirect_pc_o    = word_align(EXC_VEC);
    end else if (!stall_i && eret_req_i) begin
      redirect_valid_o = 1'b1;
      redirect_flush_o = 1'b1;
      redirect_pc_o    = word_align(epc_i);
    end else if (!stall_i && npc_taken) begin
      redirect_valid_o = 1'b1;
      redirect_pc_o    = word_align(npc_target_i);
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: owns the PC, runs the single-outstanding imem handshake
// and presents the registered instruction to the IF/ID boundary.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] EXC_VEC  = DEFAULT_EXC_VEC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_sel,
  input  logic [31:0] npc_target,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         kill_q, kill_d;
  logic         req_en_q;
  logic [31:0]  pend_pc_q, pend_pc_d;
  logic [31:0]  skid_q, skid_d;
  logic         if_valid_q, if_valid_d;
  logic [31:0]  if_instr_q, if_instr_d;
  logic [31:0]  if_pc_q, if_pc_d;
  logic [31:0]  if_pc4_q, if_pc4_d;

  logic         redirect_valid;
  logic         redirect_flush;
  logic [31:0]  redirect_pc;
  logic [31:0]  pc_plus4;
  logic         load_if;
  logic [31:0]  load_data;

  pc_redirect_arb #(
    .EXC_VEC(EXC_VEC)
  ) u_arb (
    .stall_i         (stall),
    .npc_sel_i       (npc_sel),
    .npc_target_i    (npc_target),
    .exc_req_i       (exc_req),
    .eret_req_i      (eret_req),
    .epc_i           (epc),
    .redirect_valid_o(redirect_valid),
    .redirect_flush_o(redirect_flush),
    .redirect_pc_o   (redirect_pc)
  );

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    kill_d    = kill_q;
    pend_pc_d = pend_pc_q;
    skid_d    = skid_q;
    load_if   = 1'b0;
    load_data = imem_rdata;
    unique case (state_q)
      FETCH: begin
        if (req_en_q && imem_gnt) begin
          state_d = WAIT;
          if (redirect_valid) begin
            kill_d    = 1'b1;
            pend_pc_d = redirect_pc;
          end
        end else if (redirect_valid) begin
          pc_d = redirect_pc;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_d = FETCH;
          kill_d  = 1'b0;
          if (redirect_valid) begin
            pc_d = redirect_pc;
          end else if (kill_q) begin
            pc_d = pend_pc_q;
          end else if (!stall) begin
            load_if = 1'b1;
            pc_d    = pc_plus4;
          end else begin
            // Stalled completion parks in the skid entry; pc still names it.
            skid_d  = imem_rdata;
            state_d = HOLD;
          end
        end else if (redirect_valid) begin
          kill_d    = 1'b1;
          pend_pc_d = redirect_pc;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = FETCH;
        end else if (!stall) begin
          load_if   = 1'b1;
          load_data = skid_q;
          pc_d      = pc_plus4;
          state_d   = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    if_pc4_d   = if_pc4_q;
    if (load_if) begin
      if_valid_d = 1'b1;
      if_instr_d = load_data;
      if_pc_d    = pc_q;
      if_pc4_d   = pc_plus4;
    end
    // Branch/jump redirects leave the delay-slot instruction in place.
    if (redirect_flush) begin
      if_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= FETCH;
      pc_q       <= word_align(RESET_PC);
      kill_q     <= 1'b0;
      req_en_q   <= 1'b0;
      if_valid_q <= 1'b0;
      if_instr_q <= 32'h0;
      if_pc_q    <= 32'h0;
      if_pc4_q   <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      kill_q     <= kill_d;
      req_en_q   <= 1'b1;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      if_pc4_q   <= if_pc4_d;
    end
  end

  // NOTE: pend_pc and skid are data-only; they are qualified by kill/HOLD, so they need no reset.
  always_ff @(posedge clk) begin
    pend_pc_q <= pend_pc_d;
    skid_q    <= skid_d;
  end

  // The request waits one edge after reset so a stale grant cannot be taken.
  assign imem_req  = req_en_q && (state_q == FETCH);
  assign imem_addr = word_align(pc_q);
  assign if_valid  = if_valid_q;
  assign if_instr  = if_instr_q;
  assign if_pc     = if_pc_q;
  assign if_pc4    = if_pc4_q;

endmodule
